sipo_tge: RTL and testbench
===========================

# sipo_tge

Serial-to-parallel packer for the dedispersion 10GbE path. It collects a stream of `INPUT_SIZE`-bit beats, each qualified by `i_valid`, into `OUTPUT_SIZE`-bit words and writes each completed word into a downstream FIFO. It is the receive-side counterpart of the transmit-side parallel-to-serial block that feeds the TGE core. The upstream stream cannot be stalled, so the block double-buffers the data, and when the FIFO backs up it drops and counts whole words.

## Interface
- `INPUT_SIZE`, 64: serial beat width in bits.
- `OUTPUT_SIZE`, 1024: packed word width in bits. It must be an integer multiple of `INPUT_SIZE`. `BEATS = OUTPUT_SIZE/INPUT_SIZE` (16 by default).
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `ce` input, 1 bit: clock enable. While low, no state changes and `fifo_we` is forced to 0.
- `i_serial` input, `INPUT_SIZE` bits: serial data beat.
- `i_valid` input, 1 bit: `i_serial` is accepted on any edge where `i_valid && ce`.
- `i_sync` input, 1 bit: present only with `SIPO_TGE_SYNC_EN`. Realigns word framing.
- `fifo_full` input, 1 bit: downstream FIFO full flag.
- `fifo_we` output, 1 bit: FIFO write strobe.
- `o_parallel` output, `OUTPUT_SIZE` bits: FIFO write data. It is valid whenever `fifo_we` is high.
- `overflow` output, 1 bit: one-cycle pulse when a completed word is dropped.
- `drop_count` output, 16 bits: saturating count of dropped words.

## Operation
- **Assembly register `asm` and beat counter `cnt`.**
  - `cnt` is `$clog2(BEATS)` bits wide and runs 0..`BEATS`-1.
  - Beat k of a word is written into `asm[(k+1)*INPUT_SIZE-1 : k*INPUT_SIZE]`. The first beat lands in the LSBs, which matches the transmit-side emission order.
  - Each accepted beat increments `cnt`. After beat `BEATS`-1, `cnt` wraps to 0 and the word is complete.
- **Holding register `hold`.** It drives `o_parallel` and is controlled by a two-state FSM:
  - EMPTY -> PENDING when a word completes.
  - PENDING -> EMPTY on a successful write (`fifo_we` high at the edge).
  - PENDING -> PENDING when a write and a completion occur on the same edge. `hold` takes the new word, with no gap and no drop.
- **Write strobe.** `fifo_we = ce && (state==PENDING) && !fifo_full`. This is combinational from registered state and `fifo_full`.
- **Completed word, PENDING, and no write that edge.**
  - The new word is discarded.
  - `hold` is unchanged.
  - `overflow` pulses for one cycle.
  - `drop_count` increments, saturating at 16'hFFFF.
- **Partial words.** A partially assembled word is never written. Gaps in `i_valid` simply pause assembly.
- **Reset.** All state clears immediately: `cnt`=0, FSM=EMPTY, `asm`=0, `hold`=0.
  - Reset values of outputs: `fifo_we`=0, `o_parallel`=0, `overflow`=0, `drop_count`=0.
  - If reset asserts mid-word, the partial word is lost and framing restarts at beat 0.

## Timing
- **Latency.** The last beat is accepted at edge N. `hold`/`o_parallel` is updated at N and `fifo_we` is high in cycle N..N+1 if `fifo_full` is low. The write commits at edge N+1.
- **Throughput.** One beat per cycle sustained, which gives one word every `BEATS` cycles with no bubbles.
- **Backpressure tolerance.** `fifo_full` may stay high for up to `BEATS`-1 cycles after a word reaches `hold` without any loss.
- **`ce` low.** `i_valid` beats are ignored, not buffered. `overflow` stays 0 and `fifo_we` stays 0.

## Configuration
- **`SIPO_TGE_SYNC_EN` defined:** the `i_sync` port exists.
  - `i_sync && ce` at an edge forces `cnt` to 0 and discards any partial `asm` content.
  - If `i_valid` is also high on that edge, that beat is taken as beat 0 of a new word, so `cnt` becomes 1.
  - `i_sync` does not affect `hold` or the FSM.
- **`SIPO_TGE_SYNC_EN` undefined:** there is no `i_sync` port. Framing is set only by reset and by counting beats.

## Test plan
- **Basic packing.**
  - Stimulus: 16 consecutive beats with values 0..15, `fifo_full`=0.
  - Response: a single `fifo_we` pulse, one cycle after the last beat, with `o_parallel[64k+63:64k]`=k for k=0..15.
- **Streaming.**
  - Stimulus: 64 back-to-back beats.
  - Response: exactly 4 `fifo_we` pulses, spaced 16 cycles apart, with `overflow` never asserted.
- **Backpressure.**
  - Stimulus: `fifo_full`=1 for 10 cycles after word 0 completes.
  - Response: `fifo_we` is held low during those cycles, word 0 is written once `fifo_full` falls, word 1 is intact, and `drop_count`=0.
- **Overflow.**
  - Stimulus: `fifo_full` held high across 3 completed words.
  - Response: word 0 remains in `hold`, `overflow` pulses twice, and `drop_count`=2. After `fifo_full` is released, word 0 is written and nothing else.
- **Reset mid-word.**
  - Stimulus: assert `rst` after 7 beats, then send 16 beats of value 16'hA5.
  - Response: all outputs are 0 during reset, then exactly one word of all-A5 beats is written.
- **Sync (`SIPO_TGE_SYNC_EN` defined).**
  - Stimulus: 5 beats, then `i_sync` together with a beat of value 100, then 15 more beats.
  - Response: one word is written with beat 0 = 100, and the first 5 beats never appear.

Source files
------------

// File: rtl/sipo_tge_if.sv
// Beat stream and FIFO-write bundle for sipo_tge. The i_sync member exists only
// when SIPO_TGE_SYNC_EN is defined. "slave" is the packer's view of the bundle.
interface sipo_tge_if #(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 1024
);
  logic [INPUT_SIZE-1:0]  i_serial;
  logic                   i_valid;
`ifdef SIPO_TGE_SYNC_EN
  logic                   i_sync;
`endif
  logic                   fifo_full;
  logic                   fifo_we;
  logic [OUTPUT_SIZE-1:0] o_parallel;
  logic                   overflow;
  logic [15:0]            drop_count;

`ifdef SIPO_TGE_SYNC_EN
  modport master (output i_serial, i_valid, i_sync, fifo_full,
                  input  fifo_we, o_parallel, overflow, drop_count);
  modport slave  (input  i_serial, i_valid, i_sync, fifo_full,
                  output fifo_we, o_parallel, overflow, drop_count);
`else
  modport master (output i_serial, i_valid, fifo_full,
                  input  fifo_we, o_parallel, overflow, drop_count);
  modport slave  (input  i_serial, i_valid, fifo_full,
                  output fifo_we, o_parallel, overflow, drop_count);
`endif
endinterface

// File: rtl/sipo_tge.sv
// Serial-to-parallel packer: INPUT_SIZE-bit beats into OUTPUT_SIZE-bit FIFO words,
// double-buffered, dropping and counting whole words on backpressure. Option: SIPO_TGE_SYNC_EN.
module sipo_tge #(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 1024
) (
  input logic       clk,
  input logic       rst,
  input logic       ce,
  sipo_tge_if.slave bus
);
  localparam int BEATS = OUTPUT_SIZE / INPUT_SIZE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic {S_EMPTY = 1'b0, S_PENDING = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_idx;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [OUTPUT_SIZE-1:0] r_asm;
  logic [OUTPUT_SIZE-1:0] r_hold;
  logic [OUTPUT_SIZE-1:0] w_word;
  logic                   r_overflow;
  logic [15:0]            r_drop_count;
  logic                   w_accept;
  logic                   w_sync;
  logic                   w_complete;
  logic                   w_we;
  logic                   w_drop;

`ifdef SIPO_TGE_SYNC_EN
  assign w_sync = ce & bus.i_sync;
`else
  assign w_sync = 1'b0;
`endif

  // A sync beat is always slot 0 of a fresh word.
  assign w_accept   = ce & bus.i_valid;
  assign w_idx      = w_sync ? {CNT_W{1'b0}} : r_cnt;
  assign w_complete = w_accept && (w_idx == LAST);
  assign w_drop     = w_complete && (r_state == S_PENDING) && !w_we;

  // Assembly contents including the beat presented this cycle
  always_comb begin
    w_word = w_sync ? {OUTPUT_SIZE{1'b0}} : r_asm;
    w_word[int'(w_idx)*INPUT_SIZE +: INPUT_SIZE] = bus.i_serial;
  end

  // Beat counter next value
  always_comb begin
    if (w_complete) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_accept) begin
      w_cnt_nxt = w_idx + CNT_W'(1);
    end else if (w_sync) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Framing counter and assembly register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_asm <= {OUTPUT_SIZE{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_complete || (w_sync && !w_accept)) begin
        r_asm <= {OUTPUT_SIZE{1'b0}};
      end else if (w_accept) begin
        r_asm <= w_word;
      end else begin
        r_asm <= r_asm;
      end
    end
  end

  // Holding-register FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holding-register FSM next state
  always_comb begin
    case (r_state)
      S_EMPTY:   w_state_nxt = w_complete ? S_PENDING : S_EMPTY;
      S_PENDING: w_state_nxt = (w_we && !w_complete) ? S_EMPTY : S_PENDING;
      default:   w_state_nxt = S_EMPTY;
    endcase
  end

  // Holding-register FSM output
  always_comb begin
    case (r_state)
      S_PENDING: w_we = ce && !bus.fifo_full;
      S_EMPTY:   w_we = 1'b0;
      default:   w_we = 1'b0;
    endcase
  end

  // Holding register, drop pulse and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold       <= {OUTPUT_SIZE{1'b0}};
      r_overflow   <= 1'b0;
      r_drop_count <= 16'h0000;
    end else begin
      if (w_complete && ((r_state == S_EMPTY) || w_we)) begin
        r_hold <= w_word;
      end else begin
        r_hold <= r_hold;
      end
      r_overflow <= w_drop;
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end else begin
        r_drop_count <= r_drop_count;
      end
    end
  end

  assign bus.fifo_we    = w_we;
  assign bus.o_parallel = r_hold;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
endmodule

// File: tb/tb_sipo_tge.sv
// Directed bench for sipo_tge: a word-level reference model checked every cycle,
// plus hand-computed checks of written words, latency and drop counts.
module tb_sipo_tge;
  localparam int IW = 64;
  localparam int OW = 1024;
  localparam int NB = OW / IW;

  logic clk;
  logic rst;
  logic ce;

  sipo_tge_if #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) bus ();

  sipo_tge #(.INPUT_SIZE(IW), .OUTPUT_SIZE(OW)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_n = 0;
  int mis_n = 0;
  int cyc_n = 0;
  int ovf_n = 0;
  logic [OW-1:0] wr_q[$];
  int            wc_q[$];

  // Reference model: list of beats gathered so far, one pending word, drop tally.
  logic [IW-1:0] m_beat [NB];
  int            m_n;
  logic          m_pend;
  logic [OW-1:0] m_hold;
  logic          m_ovf;
  logic [15:0]   m_drops;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    vec_n++;
    if (act !== exp) begin
      mis_n++;
      for (int k = 0; k < NB; k++) begin
        if (act[k*IW +: IW] !== exp[k*IW +: IW]) begin
          $display("FAIL %s beat%0d act=%h exp=%h t=%0t", nm, k,
                   act[k*IW +: IW], exp[k*IW +: IW], $time);
          break;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n     <= 0;
      m_pend  <= 1'b0;
      m_hold  <= '0;
      m_ovf   <= 1'b0;
      m_drops <= 16'h0000;
    end else begin : upd
      automatic int            n     = m_n;
      automatic logic          s     = 1'b0;
      automatic logic          done  = 1'b0;
      automatic logic [OW-1:0] w     = '0;
      automatic logic          wrote = ce && m_pend && !bus.fifo_full;
`ifdef SIPO_TGE_SYNC_EN
      s = bus.i_sync;
`endif
      if (ce && s) n = 0;
      if (ce && bus.i_valid) begin
        for (int k = 0; k < n; k++) w[k*IW +: IW] = m_beat[k];
        w[n*IW +: IW] = bus.i_serial;
        m_beat[n] <= bus.i_serial;
        done = (n == NB - 1);
        n = done ? 0 : n + 1;
      end
      m_n   <= n;
      m_ovf <= 1'b0;
      if (done) begin
        if (!m_pend || wrote) begin
          m_hold <= w;
          m_pend <= 1'b1;
        end else begin
          m_ovf   <= 1'b1;
          m_drops <= (m_drops == 16'hFFFF) ? m_drops : m_drops + 16'd1;
        end
      end else if (wrote) begin
        m_pend <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model; also logs committed writes.
  always @(negedge clk) begin
    cyc_n++;
    chk("fifo_we", 64'(bus.fifo_we), 64'(ce && m_pend && !bus.fifo_full));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("drop_count", 64'(bus.drop_count), 64'(m_drops));
    chkw("o_parallel", bus.o_parallel, m_hold);
    if (bus.overflow === 1'b1) ovf_n++;
    if (bus.fifo_we === 1'b1) begin
      wr_q.push_back(bus.o_parallel);
      wc_q.push_back(cyc_n);
    end
  end

  task automatic cyc(input logic v, input logic [IW-1:0] d, input logic f,
                     input logic c, input logic s);
    bus.i_valid   = v;
    bus.i_serial  = d;
    bus.fifo_full = f;
    ce            = c;
`ifdef SIPO_TGE_SYNC_EN
    bus.i_sync    = s;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, f, 1'b1, 1'b0);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wc_q.delete();
    ovf_n = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
    idle(1, 1'b0);
  endtask

  // Checks logged word idx holds beat k = base + k*step.
  task automatic chk_word(input string nm, input int idx, input logic [63:0] base,
                          input logic [63:0] step);
    if (idx < wr_q.size()) begin
      for (int k = 0; k < NB; k++)
        chk(nm, wr_q[idx][k*IW +: IW], base + 64'(k) * step);
    end else begin
      chk({nm, "_present"}, 64'(wr_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_serial  = '0;
    bus.fifo_full = 1'b0;
`ifdef SIPO_TGE_SYNC_EN
    bus.i_sync    = 1'b0;
`endif
    idle(3, 1'b0);
    chk("rst_we", 64'(bus.fifo_we), 64'd0);
    chk("rst_par", 64'(bus.o_parallel[63:0]), 64'd0);
    chk("rst_drop", 64'(bus.drop_count), 64'd0);
    rst = 1'b0;
    idle(1, 1'b0);

    // basic packing
    clear_log();
    for (int k = 0; k < NB; k++) cyc(1'b1, 64'(k), 1'b0, 1'b1, 1'b0);
    chk("basic_we_latency", 64'(bus.fifo_we), 64'd1);
    chk("basic_beat0", bus.o_parallel[63:0], 64'd0);
    chk("basic_beat15", bus.o_parallel[1023:960], 64'd15);
    idle(3, 1'b0);
    chk("basic_writes", 64'(wr_q.size()), 64'd1);
    chk_word("basic_word", 0, 64'd0, 64'd1);

    // streaming, 64 back-to-back beats
    clear_log();
    for (int k = 0; k < 4 * NB; k++) cyc(1'b1, 64'(100 + k), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("stream_writes", 64'(wr_q.size()), 64'd4);
    for (int i = 0; i + 1 < wc_q.size(); i++)
      chk("stream_spacing", 64'(wc_q[i+1] - wc_q[i]), 64'd16);
    chk("stream_ovf", 64'(ovf_n), 64'd0);
    chk_word("stream_w3", 3, 64'd148, 64'd1);

    // backpressure for 10 cycles after word 0
    do_reset();
    clear_log();
    for (int k = 0; k < NB; k++) cyc(1'b1, 64'(200 + k), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NB; k++) cyc(1'b1, 64'(300 + k), (k < 10), 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("bp_writes", 64'(wr_q.size()), 64'd2);
    chk_word("bp_w0", 0, 64'd200, 64'd1);
    chk_word("bp_w1", 1, 64'd300, 64'd1);
    chk("bp_drop", 64'(bus.drop_count), 64'd0);

    // overflow: full across 3 words
    do_reset();
    clear_log();
    for (int k = 0; k < 3 * NB; k++) cyc(1'b1, 64'(400 + k), 1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("ovf_hold", bus.o_parallel[63:0], 64'd400);
    chk("ovf_pulses", 64'(ovf_n), 64'd2);
    chk("ovf_drop", 64'(bus.drop_count), 64'd2);
    idle(4, 1'b0);
    chk("ovf_writes", 64'(wr_q.size()), 64'd1);
    chk_word("ovf_w0", 0, 64'd400, 64'd1);

    // reset after 7 beats
    clear_log();
    for (int k = 0; k < 7; k++) cyc(1'b1, 64'(500 + k), 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_drop", 64'(bus.drop_count), 64'd0);
    chk("mid_rst_par", bus.o_parallel[63:0], 64'd0);
    chk("mid_rst_we", 64'(bus.fifo_we), 64'd0);
    idle(2, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < NB; k++) cyc(1'b1, 64'hA5, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("mid_rst_writes", 64'(wr_q.size()), 64'd1);
    chk_word("mid_rst_word", 0, 64'hA5, 64'd0);

    // clock-enable low ignores beats and suppresses writes
    clear_log();
    for (int k = 0; k < 8; k++) cyc(1'b1, 64'(600 + k), 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 64'(700 + k), 1'b0, 1'b0, 1'b0);
    for (int k = 8; k < NB; k++) cyc(1'b1, 64'(600 + k), 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("ce_low_no_write", 64'(wr_q.size()), 64'd0);
    idle(2, 1'b0);
    chk("ce_writes", 64'(wr_q.size()), 64'd1);
    chk_word("ce_word", 0, 64'd600, 64'd1);

`ifdef SIPO_TGE_SYNC_EN
    clear_log();
    for (int k = 0; k < 5; k++) cyc(1'b1, 64'(1 + k), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 64'd100, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k < NB; k++) cyc(1'b1, 64'(100 + k), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("sync_writes", 64'(wr_q.size()), 64'd1);
    chk_word("sync_word", 0, 64'd100, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
    $finish;
  end
endmodule
